mem_stall_ctrl: RTL and testbench

- Central stall/flush generator for the 5-stage pipeline.
- Produces the stall vector and flush that the inter-stage registers consume.
- Arbitrates the single memory-controller port between IF (fetch) and MEM (load/store).
- Keeps the pipeline frozen for exactly the cycles each requester is waiting, and drops in-flight fetches made stale by a jump.

---
 rtl/mem_stall_ctrl_pkg.sv | 11 +
 rtl/mem_stall_ctrl_if.sv | 31 +++
 rtl/mem_stall_ctrl_port_arbiter.sv | 52 +++++
 rtl/mem_stall_ctrl.sv | 54 +++++
 tb/tb_mem_stall_ctrl.sv | 109 ++++++++++
 5 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// mem_stall_ctrl_pkg: stall encodings, stall/jump constants and arbiter state codes shared by the stall controller
package mem_stall_ctrl_pkg;
  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_IF = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic STALL = 1'b1;
  localparam logic NO_STALL = 1'b0;
  localparam logic JUMP = 1'b1;
  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;
endpackage

// File: rtl/mem_stall_ctrl_if.sv
// mem_stall_ctrl_if: pipeline <-> stall controller bundle
//   pipeline side (master) drives rdy_in, ifReq_in, memReq_in, idStallReq_in, pcJump_in, portDone_in
//   controller side (slave) drives grants, done pulses, flush_out, stall_out
//   STALL_CNT_EN adds memStallCnt_out/idStallCnt_out/ifStallCnt_out (CNT_W bits)
interface mem_stall_ctrl_if #(
  parameter int STALL_W = 6
`ifdef STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  logic rdy_in, ifReq_in, memReq_in, idStallReq_in, pcJump_in, portDone_in;
  logic ifGrant_out, memGrant_out, ifDone_out, memDone_out, flush_out;
  logic [STALL_W-1:0] stall_out;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] memStallCnt_out, idStallCnt_out, ifStallCnt_out;
`endif
  modport master (
    output rdy_in, ifReq_in, memReq_in, idStallReq_in, pcJump_in, portDone_in,
    input ifGrant_out, memGrant_out, ifDone_out, memDone_out, flush_out, stall_out
`ifdef STALL_CNT_EN
    , input memStallCnt_out, idStallCnt_out, ifStallCnt_out
`endif
  );
  modport slave (
    input rdy_in, ifReq_in, memReq_in, idStallReq_in, pcJump_in, portDone_in,
    output ifGrant_out, memGrant_out, ifDone_out, memDone_out, flush_out, stall_out
`ifdef STALL_CNT_EN
    , output memStallCnt_out, idStallCnt_out, ifStallCnt_out
`endif
  );
endinterface

// File: rtl/mem_stall_ctrl_port_arbiter.sv
// mem_stall_ctrl_port_arbiter: IF/MEM arbitration of the single memory port with stale-fetch discard
//   clk_in, rst_in (async, active-low); i_rdy freezes state
//   i_if_req / i_mem_req level requests, i_jump taken jump, i_done port completion pulse
//   o_if_grant / o_mem_grant registered grants, o_if_done / o_mem_done completion to requesters
module mem_stall_ctrl_port_arbiter
  import mem_stall_ctrl_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_rdy,
  input  logic i_if_req,
  input  logic i_mem_req,
  input  logic i_jump,
  input  logic i_done,
  output logic o_if_grant,
  output logic o_mem_grant,
  output logic o_if_done,
  output logic o_mem_done
);
  state_t r_state, w_state_nxt;
  logic r_discard, w_discard_nxt, r_if_grant, r_mem_grant;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      r_state <= IDLE;
      r_discard <= 1'b0;
      r_if_grant <= 1'b0;
      r_mem_grant <= 1'b0;
    end else if (i_rdy) begin
      r_state <= w_state_nxt;
      r_discard <= w_discard_nxt;
      r_if_grant <= w_state_nxt == IF_BUSY;
      r_mem_grant <= w_state_nxt == MEM_BUSY;
    end
  // Completion always returns to IDLE, giving the mandatory turnaround cycle.
  // A jump mid-fetch marks the outstanding fetch stale until its data returns.
  always_comb begin
    w_state_nxt = r_state;
    w_discard_nxt = r_discard;
    if (r_state == IDLE)
      w_state_nxt = i_mem_req ? MEM_BUSY : i_if_req ? IF_BUSY : IDLE;
    else if (i_done) begin
      w_state_nxt = IDLE;
      w_discard_nxt = 1'b0;
    end else if (r_state == IF_BUSY && i_jump == JUMP)
      w_discard_nxt = 1'b1;
  end
  assign o_if_grant = r_if_grant;
  assign o_mem_grant = r_mem_grant;
  assign o_mem_done = i_done & (r_state == MEM_BUSY);
  // A jump coinciding with the data return squashes it directly.
  assign o_if_done = i_done & (r_state == IF_BUSY) & ~r_discard & (i_jump != JUMP);
endmodule

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: pipeline stall vector / flush generator and IF-vs-MEM memory port arbiter
//   clk_in, rst_in (async, active-low); bus: mem_stall_ctrl_if.slave (requests in, grants/done/flush/stall out)
//   optional STALL_CNT_EN: saturating per-cause stall counters on the bus
module mem_stall_ctrl
  import mem_stall_ctrl_pkg::*;
#(
  parameter int STALL_W = 6
`ifdef STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic clk_in,
  input logic rst_in,
  mem_stall_ctrl_if.slave bus
);
  logic w_mem_sel, w_id_sel, w_if_sel;
  logic [5:0] w_stall;
  mem_stall_ctrl_port_arbiter u_arb (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .i_rdy(bus.rdy_in),
    .i_if_req(bus.ifReq_in),
    .i_mem_req(bus.memReq_in),
    .i_jump(bus.pcJump_in),
    .i_done(bus.portDone_in),
    .o_if_grant(bus.ifGrant_out),
    .o_mem_grant(bus.memGrant_out),
    .o_if_done(bus.ifDone_out),
    .o_mem_done(bus.memDone_out)
  );
  // Mutually exclusive priority selects: MEM wait > load-use > IF wait.
  assign w_mem_sel = (bus.memReq_in == STALL) & ~bus.memDone_out;
  assign w_id_sel = ~w_mem_sel & (bus.idStallReq_in == STALL);
  assign w_if_sel = ~w_mem_sel & ~w_id_sel & (bus.ifReq_in == STALL) & ~bus.ifDone_out;
  assign w_stall = w_mem_sel ? STALL_MEM : w_id_sel ? STALL_ID : w_if_sel ? STALL_IF : STALL_NONE;
  assign bus.stall_out = STALL_W'(w_stall);
  assign bus.flush_out = bus.pcJump_in == JUMP;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] r_mem_cnt, r_id_cnt, r_if_cnt;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      r_mem_cnt <= '0;
      r_id_cnt <= '0;
      r_if_cnt <= '0;
    end else if (bus.rdy_in) begin
      r_mem_cnt <= r_mem_cnt + {{(CNT_W-1){1'b0}}, w_mem_sel & ~&r_mem_cnt};
      r_id_cnt <= r_id_cnt + {{(CNT_W-1){1'b0}}, w_id_sel & ~&r_id_cnt};
      r_if_cnt <= r_if_cnt + {{(CNT_W-1){1'b0}}, w_if_sel & ~&r_if_cnt};
    end
  assign bus.memStallCnt_out = r_mem_cnt;
  assign bus.idStallCnt_out = r_id_cnt;
  assign bus.ifStallCnt_out = r_if_cnt;
`endif
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: directed vectors with a queued-expectation scoreboard for mem_stall_ctrl
module tb_mem_stall_ctrl;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int checks = 0;
  int failures = 0;
  mem_stall_ctrl_if bus ();
  mem_stall_ctrl dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  typedef struct {
    string name;
    logic [10:0] exp;
    int unsigned cm, ci, cf;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int unsigned m_cm = 0, m_ci = 0, m_cf = 0;
  logic [10:0] m_got;
  // in = {rst, rdy, ifReq, memReq, idStall, jump, portDone}
  // exp = {ifGrant, memGrant, ifDone, memDone, flush, stall[5:0]} sampled mid-cycle
  task automatic cyc(input string name, input logic [6:0] in, input logic [10:0] exp);
    exp_t e;
    @(posedge clk_in);
    #1;
    {rst_in, bus.rdy_in, bus.ifReq_in, bus.memReq_in, bus.idStallReq_in, bus.pcJump_in, bus.portDone_in} = in;
    if (!in[6]) begin
      m_cm = 0;
      m_ci = 0;
      m_cf = 0;
    end
    e.name = name;
    e.exp = exp;
    e.cm = m_cm;
    e.ci = m_ci;
    e.cf = m_cf;
    q.push_back(e);
    if (in[6] && in[5]) begin
      if (exp[5:0] == 6'b011111) m_cm++;
      if (exp[5:0] == 6'b000111) m_ci++;
      if (exp[5:0] == 6'b000011) m_cf++;
    end
  endtask
  always @(negedge clk_in)
    if (q.size() > 0) begin
      m_e = q.pop_front();
      m_got = {bus.ifGrant_out, bus.memGrant_out, bus.ifDone_out, bus.memDone_out, bus.flush_out, bus.stall_out};
      checks++;
      if (m_got !== m_e.exp) begin
        failures++;
        $display("FAIL %s got={ifg,memg,ifd,memd,fl,stall}=%b expected=%b", m_e.name, m_got, m_e.exp);
      end
`ifdef STALL_CNT_EN
      checks++;
      if (bus.memStallCnt_out !== m_e.cm || bus.idStallCnt_out !== m_e.ci || bus.ifStallCnt_out !== m_e.cf) begin
        failures++;
        $display("FAIL %s_cnt got=%0d/%0d/%0d expected=%0d/%0d/%0d", m_e.name,
                 bus.memStallCnt_out, bus.idStallCnt_out, bus.ifStallCnt_out, m_e.cm, m_e.ci, m_e.cf);
      end
`endif
    end
  initial begin
    {bus.rdy_in, bus.ifReq_in, bus.memReq_in, bus.idStallReq_in, bus.pcJump_in, bus.portDone_in} = '0;
    cyc("reset0", 7'b0_1_00000, 11'b0_0_0_0_0_000000);
    cyc("reset1", 7'b0_1_00000, 11'b0_0_0_0_0_000000);
    cyc("idle", 7'b1_1_00000, 11'b0_0_0_0_0_000000);
    cyc("loaduse", 7'b1_1_0_0_1_0_0, 11'b0_0_0_0_0_000111);
    cyc("loaduse_end", 7'b1_1_00000, 11'b0_0_0_0_0_000000);
    cyc("arb_req", 7'b1_1_1_1_0_0_0, 11'b0_0_0_0_0_011111);
    cyc("arb_memg", 7'b1_1_1_1_0_0_0, 11'b0_1_0_0_0_011111);
    cyc("arb_wait", 7'b1_1_1_1_0_0_0, 11'b0_1_0_0_0_011111);
    cyc("arb_memdone", 7'b1_1_1_1_0_0_1, 11'b0_1_0_1_0_000011);
    cyc("arb_turn", 7'b1_1_1_0_0_0_0, 11'b0_0_0_0_0_000011);
    cyc("arb_ifg", 7'b1_1_1_0_0_0_0, 11'b1_0_0_0_0_000011);
    cyc("jmp_flush", 7'b1_1_1_0_0_1_0, 11'b1_0_0_0_1_000011);
    cyc("jmp_wait", 7'b1_1_1_0_0_0_0, 11'b1_0_0_0_0_000011);
    cyc("jmp_drop", 7'b1_1_1_0_0_0_1, 11'b1_0_0_0_0_000011);
    cyc("jmp_idle", 7'b1_1_1_0_0_0_0, 11'b0_0_0_0_0_000011);
    cyc("jmp_regrant", 7'b1_1_1_0_0_0_0, 11'b1_0_0_0_0_000011);
    cyc("if_done", 7'b1_1_1_0_0_0_1, 11'b1_0_1_0_0_000000);
    cyc("if_req2", 7'b1_1_1_0_0_0_0, 11'b0_0_0_0_0_000011);
    cyc("if_g2", 7'b1_1_1_0_0_0_0, 11'b1_0_0_0_0_000011);
    cyc("jmp_coinc", 7'b1_1_1_0_0_1_1, 11'b1_0_0_0_1_000011);
    cyc("coinc_idle", 7'b1_1_1_0_0_0_0, 11'b0_0_0_0_0_000011);
    cyc("coinc_g", 7'b1_1_1_0_0_0_0, 11'b1_0_0_0_0_000011);
    cyc("coinc_done", 7'b1_1_1_0_0_0_1, 11'b1_0_1_0_0_000000);
    cyc("idle_done_ign", 7'b1_1_0_0_0_0_1, 11'b0_0_0_0_0_000000);
    cyc("idle2", 7'b1_1_00000, 11'b0_0_0_0_0_000000);
    cyc("rdy_req", 7'b1_1_0_1_0_0_0, 11'b0_0_0_0_0_011111);
    for (int i = 0; i < 4; i++) cyc("rdy_hold", 7'b1_0_0_1_0_0_0, 11'b0_1_0_0_0_011111);
    cyc("rdy_resume", 7'b1_1_0_1_0_0_0, 11'b0_1_0_0_0_011111);
    cyc("rdy_resume2", 7'b1_1_0_1_0_0_0, 11'b0_1_0_0_0_011111);
    cyc("rdy_done", 7'b1_1_0_1_0_0_1, 11'b0_1_0_1_0_000000);
    cyc("rst_req", 7'b1_1_0_1_0_0_0, 11'b0_0_0_0_0_011111);
    cyc("rst_memg", 7'b1_1_0_1_0_0_0, 11'b0_1_0_0_0_011111);
    cyc("rst_mid", 7'b0_1_1_0_0_0_0, 11'b0_0_0_0_0_000011);
    cyc("rst_rel", 7'b1_1_1_0_0_0_0, 11'b0_0_0_0_0_000011);
    cyc("rst_regrant", 7'b1_1_1_0_0_0_0, 11'b1_0_0_0_0_000011);
    cyc("tail", 7'b1_1_00000, 11'b1_0_0_0_0_000000);
    repeat (2) @(negedge clk_in);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
